// File: rtl/lsu_addr_queue.sv
// LSU front end: in-order queue of AGU ops, alignment check, one outstanding
// load to data memory, tagged writeback of load data and store completions.
module lsu_addr_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       agu_valid,
    output logic                       agu_ready,
    input  logic [31:0]                agu_addr,
    input  logic                       agu_is_store,
    input  logic [2:0]                 agu_funct3,
    input  logic [31:0]                agu_wdata,
    input  logic [TAG_W-1:0]           agu_tag,
    input  logic                       flush,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [31:0]                mem_addr,
    output logic                       mem_we,
    output logic [3:0]                 mem_wstrb,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_resp_valid,
    input  logic [31:0]                mem_rdata,
    output logic                       wb_valid,
    output logic [TAG_W-1:0]           wb_tag,
    output logic [31:0]                wb_data,
    output logic                       wb_is_load,
    output logic                       wb_exc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0]      addr;
        logic             is_store;
        logic [2:0]       funct3;
        logic [31:0]      wdata;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT_RESP, DRAIN} state_t;

    entry_t            fifo_q [DEPTH];
    logic [PW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q;
    state_t            state_q, state_d;

    logic              wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              wb_is_load_q, wb_is_load_d;
    logic              wb_exc_q, wb_exc_d;

    entry_t            head;
    logic [1:0]        off;
    logic [2:0]        f3;
    logic              empty, enq, deq, exc;
    logic [3:0]        strb;
    logic [31:0]       sh, ld_data;

    assign agu_ready = (count_q != CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign enq       = agu_valid && agu_ready;
    assign head      = fifo_q[head_q];
    assign off       = head.addr[1:0];
    assign f3        = head.funct3;

    // Illegal width code, unsigned store, or misaligned halfword/word.
    assign exc = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
              || (head.is_store && f3[2])
              || ((f3[1:0] == 2'b01) && head.addr[0])
              || ((f3 == 3'b010) && (off != 2'b00));

    always_comb begin
        strb = 4'b1111;
        case (f3[1:0])
            2'b00:   strb = 4'b0001 << off;
            2'b01:   strb = 4'b0011 << off;
            default: strb = 4'b1111;
        endcase
    end

    assign mem_addr  = mem_req_valid ? {head.addr[31:2], 2'b00} : '0;
    assign mem_we    = mem_req_valid && head.is_store;
    assign mem_wstrb = mem_we ? strb : 4'b0000;
    assign mem_wdata = mem_req_valid ? (head.wdata << {off, 3'b000}) : '0;

    assign sh = mem_rdata >> {off, 3'b000};

    always_comb begin
        ld_data = sh;
        case (f3)
            3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
            3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
            3'b100:  ld_data = {24'b0, sh[7:0]};
            3'b101:  ld_data = {16'b0, sh[15:0]};
            default: ld_data = sh;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        deq           = 1'b0;
        mem_req_valid = 1'b0;
        wb_valid_d    = 1'b0;
        wb_tag_d      = head.tag;
        wb_data_d     = '0;
        wb_is_load_d  = !head.is_store;
        wb_exc_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (exc) begin
                        deq        = 1'b1;
                        wb_valid_d = !flush;
                        wb_exc_d   = 1'b1;
                    end else begin
                        mem_req_valid = 1'b1;
                        if (mem_req_ready) begin
                            if (head.is_store) begin
                                deq        = 1'b1;
                                wb_valid_d = !flush;
                            end else begin
                                // A load launched while flushing still owes a response.
                                state_d = flush ? DRAIN : WAIT_RESP;
                            end
                        end
                    end
                end
            end
            WAIT_RESP: begin
                if (mem_resp_valid) begin
                    deq        = 1'b1;
                    wb_valid_d = !flush;
                    wb_data_d  = ld_data;
                    state_d    = IDLE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_resp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (enq) begin
                    fifo_q[tail_q] <= '{agu_addr, agu_is_store, agu_funct3,
                                       agu_wdata, agu_tag};
                    tail_q <= tail_q + PW'(1);
                end
                if (deq) head_q <= head_q + PW'(1);
                count_q <= count_q + CW'(enq) - CW'(deq);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q   <= 1'b0;
            wb_tag_q     <= '0;
            wb_data_q    <= '0;
            wb_is_load_q <= 1'b0;
            wb_exc_q     <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            if (wb_valid_d) begin
                wb_tag_q     <= wb_tag_d;
                wb_data_q    <= wb_data_d;
                wb_is_load_q <= wb_is_load_d;
                wb_exc_q     <= wb_exc_d;
            end
        end
    end

    assign wb_valid   = wb_valid_q;
    assign wb_tag     = wb_tag_q;
    assign wb_data    = wb_data_q;
    assign wb_is_load = wb_is_load_q;
    assign wb_exc     = wb_exc_q;
    assign count      = count_q;

endmodule

// File: tb/tb_lsu_addr_queue.sv
// Bench for lsu_addr_queue: directed scenarios plus a randomized run
// checked against an in-order queue model of completions and requests.
module tb_lsu_addr_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             agu_valid, agu_ready, agu_is_store;
    logic [31:0]      agu_addr, agu_wdata;
    logic [2:0]       agu_funct3;
    logic [TAG_W-1:0] agu_tag;
    logic             flush;
    logic             mem_req_valid, mem_req_ready, mem_we;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [3:0]       mem_wstrb;
    logic             mem_resp_valid;
    logic             wb_valid, wb_is_load, wb_exc;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic [CW-1:0]    count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0]      addr;
        logic             st;
        logic [2:0]       f3;
        logic [31:0]      wdata;
        logic [TAG_W-1:0] tag;
    } op_t;

    lsu_addr_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .agu_valid(agu_valid), .agu_ready(agu_ready),
        .agu_addr(agu_addr), .agu_is_store(agu_is_store),
        .agu_funct3(agu_funct3), .agu_wdata(agu_wdata), .agu_tag(agu_tag),
        .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .wb_is_load(wb_is_load), .wb_exc(wb_exc), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        agu_valid = 0; agu_addr = 0; agu_is_store = 0; agu_funct3 = 0;
        agu_wdata = 0; agu_tag = 0; flush = 0; mem_req_ready = 0;
        mem_resp_valid = 0; mem_rdata = 0;
    endtask

    task automatic set_op(input logic [31:0] a, input logic st,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input logic [TAG_W-1:0] tg);
        agu_valid = 1; agu_addr = a; agu_is_store = st;
        agu_funct3 = f3; agu_wdata = wd; agu_tag = tg;
    endtask

    // Reference model: spec rules in plain arithmetic.
    function automatic logic m_exc(input op_t o);
        int sz;
        if (o.f3 == 3 || o.f3 == 6 || o.f3 == 7) return 1;
        if (o.st && o.f3 >= 4) return 1;
        sz = (o.f3 == 2) ? 4 : (o.f3 == 1 || o.f3 == 5) ? 2 : 1;
        return (o.addr % sz) != 0;
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        return {a[15:2], a[17:2], 2'b11} ^ 32'h9E3779B9;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] v;
        v = w / (32'd1 << (8 * (a % 4)));
        case (f3)
            0: begin v = v % 256;   if (v >= 128)   v = v - 32'h100;   end
            1: begin v = v % 65536; if (v >= 32768) v = v - 32'h10000; end
            4: v = v % 256;
            5: v = v % 65536;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] m_strb(input op_t o);
        int n;
        if (!o.st) return 4'b0000;
        n = (o.f3 == 2) ? 4 : (o.f3 == 1) ? 2 : 1;
        return 4'(((1 << n) - 1) << (o.addr % 4));
    endfunction

    task automatic test_reset();
        idle_in();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({agu_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
             wb_valid, wb_tag, wb_data, wb_is_load, wb_exc, count}
            !== {1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0,
                 1'b0, 6'h0, 32'h0, 1'b0, 1'b0, 3'h0}) begin
            miscompares++;
            $display("FAIL reset: rdy=%b req=%b wb=%b cnt=%0d want rdy=1 rest 0",
                     agu_ready, mem_req_valid, wb_valid, count);
        end
        rst = 1;
        tick();
    endtask

    task automatic test_load_word();
        set_op(32'h100, 0, 3'b010, 0, 3);
        tick();
        agu_valid = 0;
        vectors++;
        if ({mem_req_valid, mem_addr, mem_we, mem_wstrb} !== {1'b1, 32'h100, 1'b0, 4'h0}) begin
            miscompares++;
            $display("FAIL lw_req: v=%b a=%h we=%b s=%b want 1 00000100 0 0000",
                     mem_req_valid, mem_addr, mem_we, mem_wstrb);
        end
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        tick();
        vectors++;
        if (mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_wait: req=%b wb=%b want 0 0", mem_req_valid, wb_valid);
        end
        mem_resp_valid = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_resp_valid = 0;
        vectors++;
        if ({wb_valid, wb_tag, wb_data, wb_is_load, wb_exc}
            !== {1'b1, 6'd3, 32'hDEADBEEF, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL lw_wb: v=%b tag=%0d d=%h ld=%b exc=%b want 1 3 deadbeef 1 0",
                     wb_valid, wb_tag, wb_data, wb_is_load, wb_exc);
        end
        tick();
        vectors++;
        if (wb_valid !== 1'b0 || count !== 0) begin
            miscompares++;
            $display("FAIL lw_pulse: wb=%b cnt=%0d want 0 0", wb_valid, count);
        end
    endtask

    task automatic test_store_byte();
        set_op(32'h203, 1, 3'b000, 32'h000000A5, 5);
        tick();
        agu_valid = 0;
        vectors++;
        if ({mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata}
            !== {1'b1, 32'h200, 1'b1, 4'b1000, 32'hA5000000}) begin
            miscompares++;
            $display("FAIL sb_req: v=%b a=%h we=%b s=%b d=%h want 1 00000200 1 1000 a5000000",
                     mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata);
        end
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        vectors++;
        if ({wb_valid, wb_tag, wb_data, wb_is_load, wb_exc}
            !== {1'b1, 6'd5, 32'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL sb_wb: v=%b tag=%0d d=%h ld=%b exc=%b want 1 5 0 0 0",
                     wb_valid, wb_tag, wb_data, wb_is_load, wb_exc);
        end
        tick();
    endtask

    task automatic test_load_ext();
        logic [31:0] a [3];
        logic [2:0]  f [3];
        logic [31:0] rd [3];
        logic [31:0] ex [3];
        a  = '{32'h101, 32'h101, 32'h102};
        f  = '{3'b000, 3'b100, 3'b001};
        rd = '{32'h0000F000, 32'h0000F000, 32'h80010000};
        ex = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001};
        for (int i = 0; i < 3; i++) begin
            set_op(a[i], 0, f[i], 0, 6'(40 + i));
            tick();
            agu_valid = 0; mem_req_ready = 1;
            tick();
            mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = rd[i];
            tick();
            mem_resp_valid = 0;
            vectors++;
            if ({wb_valid, wb_tag, wb_data} !== {1'b1, 6'(40 + i), ex[i]}) begin
                miscompares++;
                $display("FAIL load_ext%0d: v=%b tag=%0d d=%h want 1 %0d %h",
                         i, wb_valid, wb_tag, wb_data, 40 + i, ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_exceptions();
        mem_req_ready = 1;
        set_op(32'h102, 0, 3'b010, 0, 7);
        tick();
        vectors++;
        if (mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL exc_noreq0: req=%b want 0", mem_req_valid);
        end
        set_op(32'h105, 1, 3'b001, 32'h1234, 8);
        tick();
        vectors++;
        if ({wb_valid, wb_tag, wb_data, wb_exc, wb_is_load, mem_req_valid}
            !== {1'b1, 6'd7, 32'h0, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL exc_lw: v=%b tag=%0d d=%h exc=%b ld=%b req=%b want 1 7 0 1 1 0",
                     wb_valid, wb_tag, wb_data, wb_exc, wb_is_load, mem_req_valid);
        end
        set_op(32'h100, 0, 3'b011, 0, 9);
        tick();
        agu_valid = 0;
        vectors++;
        if ({wb_valid, wb_tag, wb_exc, wb_is_load, mem_req_valid}
            !== {1'b1, 6'd8, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL exc_sh: v=%b tag=%0d exc=%b ld=%b req=%b want 1 8 1 0 0",
                     wb_valid, wb_tag, wb_exc, wb_is_load, mem_req_valid);
        end
        tick();
        vectors++;
        if ({wb_valid, wb_tag, wb_exc} !== {1'b1, 6'd9, 1'b1}) begin
            miscompares++;
            $display("FAIL exc_f3: v=%b tag=%0d exc=%b want 1 9 1",
                     wb_valid, wb_tag, wb_exc);
        end
        mem_req_ready = 0;
        tick();
    endtask

    task automatic test_full_wrap();
        logic [TAG_W-1:0] got [$];
        mem_req_ready = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_op(32'h300 + 4 * i, 1, 3'b010, i, 6'(20 + i));
            #1;
            vectors++;
            if (agu_ready !== 1'(i < DEPTH)) begin
                miscompares++;
                $display("FAIL full_ready%0d: rdy=%b cnt=%0d want %b",
                         i, agu_ready, count, 1'(i < DEPTH));
            end
            tick();
        end
        set_op(32'h400, 1, 3'b010, 0, 63);
        mem_req_ready = 1;
        #1;
        vectors++;
        if (agu_ready !== 1'b0 || count !== CW'(DEPTH)) begin
            miscompares++;
            $display("FAIL full_deq_ready: rdy=%b cnt=%0d want 0 %0d",
                     agu_ready, count, DEPTH);
        end
        tick();
        agu_valid = 0;
        for (int c = 0; c < 3 * DEPTH; c++) begin
            if (wb_valid) got.push_back(wb_tag);
            tick();
        end
        mem_req_ready = 0;
        vectors++;
        if (got.size() != DEPTH || count !== 0) begin
            miscompares++;
            $display("FAIL full_drain: wbs=%0d cnt=%0d want %0d 0",
                     got.size(), count, DEPTH);
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] !== 6'(20 + i)) begin
                miscompares++;
                $display("FAIL full_order%0d: tag=%0d want %0d", i, got[i], 20 + i);
            end
        end
    endtask

    task automatic test_flush();
        set_op(32'h100, 0, 3'b010, 0, 10);
        tick();
        agu_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0; flush = 1;
        tick();
        flush = 0;
        set_op(32'h104, 0, 3'b010, 0, 11);
        #1;
        vectors++;
        if (agu_ready !== 1'b1 || count !== 0 || wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drain_enq: rdy=%b cnt=%0d wb=%b want 1 0 0",
                     agu_ready, count, wb_valid);
        end
        tick();
        agu_valid = 0; mem_req_ready = 1;
        mem_resp_valid = 1; mem_rdata = 32'h11111111;
        #1;
        vectors++;
        if (mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drain_req: req=%b want 0", mem_req_valid);
        end
        tick();
        mem_resp_valid = 0;
        vectors++;
        if (wb_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_addr !== 32'h104) begin
            miscompares++;
            $display("FAIL flush_stale: wb=%b req=%b a=%h want 0 1 00000104",
                     wb_valid, mem_req_valid, mem_addr);
        end
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h22222222;
        tick();
        mem_resp_valid = 0;
        vectors++;
        if ({wb_valid, wb_tag, wb_data} !== {1'b1, 6'd11, 32'h22222222}) begin
            miscompares++;
            $display("FAIL flush_new: v=%b tag=%0d d=%h want 1 11 22222222",
                     wb_valid, wb_tag, wb_data);
        end
        tick();
    endtask

    task automatic test_async_reset();
        set_op(32'h40, 0, 3'b010, 0, 12);
        tick();
        agu_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        #2;
        rst = 0;
        #1;
        vectors++;
        if ({count, agu_ready, mem_req_valid, wb_valid} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: cnt=%0d rdy=%b req=%b wb=%b want 0 1 0 0",
                     count, agu_ready, mem_req_valid, wb_valid);
        end
        @(posedge clk);
        #1;
        rst = 1;
        set_op(32'h44, 1, 3'b010, 32'h5, 13);
        tick();
        agu_valid = 0;
        vectors++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h44) begin
            miscompares++;
            $display("FAIL async_idle: req=%b a=%h want 1 00000044",
                     mem_req_valid, mem_addr);
        end
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        tick();
    endtask

    task automatic test_random();
        op_t         wbq [$];
        op_t         reqq [$];
        op_t         o, r, ld;
        logic [2:0]  f3s [10];
        logic [31:0] exp_d;
        logic        load_out = 0;
        logic        resp_now;
        int          dly = 0;
        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (wb_valid) begin
                vectors++;
                if (wbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_wb_extra: tag=%0d with no op pending", wb_tag);
                end else begin
                    o = wbq.pop_front();
                    exp_d = (m_exc(o) || o.st) ? 32'h0 : m_load(o.f3, o.addr, m_word(o.addr));
                    if ({wb_tag, wb_data, wb_is_load, wb_exc} !== {o.tag, exp_d, !o.st, m_exc(o)}) begin
                        miscompares++;
                        $display("FAIL rnd_wb: tag=%0d d=%h ld=%b exc=%b want %0d %h %b %b",
                                 wb_tag, wb_data, wb_is_load, wb_exc,
                                 o.tag, exp_d, !o.st, m_exc(o));
                    end
                end
            end
            if (cyc < 600 && $urandom_range(0, 9) < 6) begin
                o.st = 1'($urandom_range(0, 1));
                o.f3 = f3s[$urandom_range(0, 9)];
                o.addr = $urandom;
                if ($urandom_range(0, 3) != 0) o.addr[1:0] = 2'b00;
                o.wdata = $urandom;
                o.tag = TAG_W'($urandom);
                set_op(o.addr, o.st, o.f3, o.wdata, o.tag);
            end else begin
                agu_valid = 0;
            end
            mem_req_ready = 1'($urandom_range(0, 1));
            resp_now = load_out && dly == 0;
            if (resp_now) begin
                mem_resp_valid = 1;
                mem_rdata = m_word(ld.addr);
            end else begin
                mem_resp_valid = !load_out && $urandom_range(0, 9) == 0;
                mem_rdata = $urandom;
            end
            #1;
            if (agu_valid && agu_ready) begin
                wbq.push_back(o);
                if (!m_exc(o)) reqq.push_back(o);
            end
            if (load_out) begin
                vectors++;
                if (mem_req_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_outstanding: req=%b while load pending", mem_req_valid);
                end
            end
            if (resp_now) load_out = 0;
            else if (load_out) dly--;
            if (mem_req_valid && mem_req_ready) begin
                vectors++;
                if (reqq.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_req_extra: a=%h with no legal op pending", mem_addr);
                end else begin
                    r = reqq.pop_front();
                    if ({mem_addr, mem_we, mem_wstrb} !== {r.addr & ~32'h3, r.st, m_strb(r)}
                        || (r.st && mem_wdata !== r.wdata * (32'd1 << (8 * (r.addr % 4))))) begin
                        miscompares++;
                        $display("FAIL rnd_req: a=%h we=%b s=%b d=%h want a=%h we=%b s=%b",
                                 mem_addr, mem_we, mem_wstrb, mem_wdata,
                                 r.addr & ~32'h3, r.st, m_strb(r));
                    end
                    if (!r.st) begin
                        load_out = 1;
                        ld = r;
                        dly = $urandom_range(0, 3);
                    end
                end
            end
            tick();
        end
        idle_in();
        vectors++;
        if (wbq.size() != 0 || reqq.size() != 0) begin
            miscompares++;
            $display("FAIL rnd_drain: %0d completions %0d requests left, want 0 0",
                     wbq.size(), reqq.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_load_ext();
        test_exceptions();
        test_full_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
